// File: rtl/comb_chain.sv
// CIC comb section: N cascaded y[n] = x[n] - x[n-M] stages with independent
// delay history for CH time-multiplexed channels sharing one datapath.
module comb_chain #(
   parameter int IW = 19,
   parameter int OW = 19,
   parameter int N  = 3,
   parameter int M  = 1,
   parameter int CH = 2,
   parameter int CW = 1
) (
   input  logic          lr_clock,
   input  logic          reset,
   input  logic          i_valid,
   input  logic [CW-1:0] i_ch,
   input  logic [IW-1:0] i_data,
   output logic          o_valid,
   output logic [CW-1:0] o_ch,
   output logic [OW-1:0] o_data
);

   localparam logic [CW:0] CH_LIM = (CW+1)'(CH);

   // Slot 0 of each pipe is the conditioned input; slot k is stage k's register.
   logic [N:0]           v_pipe;
   logic [(N+1)*CW-1:0]  ch_pipe;
   logic [(N+1)*OW-1:0]  d_pipe;

   // Out-of-range channel indices are dropped before they can touch any state.
   assign v_pipe[0]          = i_valid && ({1'b0, i_ch} < CH_LIM);
   assign ch_pipe[0 +: CW]   = i_ch;
   assign d_pipe[0 +: OW]    = OW'($signed(i_data));

   genvar gi, ci;
   generate
      for (gi = 0; gi < N; gi++) begin : g_stage
         logic          stg_v;
         logic [CW-1:0] stg_ch;
         logic [OW-1:0] stg_d;
         logic [CH*OW-1:0] tap_flat;
         logic [OW-1:0] tap_sel;
         logic          v_reg;
         logic [CW-1:0] ch_reg;
         logic [OW-1:0] d_reg;

         assign stg_v  = v_pipe[gi];
         assign stg_ch = ch_pipe[gi*CW +: CW];
         assign stg_d  = d_pipe[gi*OW +: OW];

         for (ci = 0; ci < CH; ci++) begin : g_chan
            logic [OW-1:0] dly_reg [M];

            // Only the line of the channel carried by this valid sample advances.
            always_ff @(posedge lr_clock or posedge reset) begin
               if (reset) begin
                  for (int m = 0; m < M; m++) dly_reg[m] <= '0;
               end else if (stg_v && (stg_ch == CW'(ci))) begin
                  dly_reg[0] <= stg_d;
                  for (int m = 1; m < M; m++) dly_reg[m] <= dly_reg[m-1];
               end
            end

            assign tap_flat[ci*OW +: OW] = dly_reg[M-1];
         end

         always_comb begin
            tap_sel = '0;
            for (int c = 0; c < CH; c++) begin
               if (stg_ch == CW'(c)) tap_sel = tap_flat[c*OW +: OW];
            end
         end

         // Channel and data hold through bubbles so the output stays stable.
         always_ff @(posedge lr_clock or posedge reset) begin
            if (reset) begin
               v_reg  <= 1'b0;
               ch_reg <= '0;
               d_reg  <= '0;
            end else begin
               v_reg <= stg_v;
               if (stg_v) begin
                  ch_reg <= stg_ch;
                  d_reg  <= stg_d - tap_sel;
               end
            end
         end

         assign v_pipe[gi+1]              = v_reg;
         assign ch_pipe[(gi+1)*CW +: CW]  = ch_reg;
         assign d_pipe[(gi+1)*OW +: OW]   = d_reg;
      end
   endgenerate

   assign o_valid = v_pipe[N];
   assign o_ch    = ch_pipe[N*CW +: CW];
   assign o_data  = d_pipe[N*OW +: OW];

endmodule

// File: tb/tb_comb_chain.sv
// Scoreboard bench for comb_chain: the reference model expands the N-stage comb
// as a binomial FIR over each channel's accepted-sample history.
module tb_comb_chain;
   localparam int IW = 19;
   localparam int OW = 19;
   localparam int N  = 3;
   localparam int M  = 2;
   localparam int CH = 3;
   localparam int CW = 2;
   localparam int HL = N*M + 1;

   logic          lr_clock = 1'b0;
   logic          reset    = 1'b1;
   logic          i_valid  = 1'b0;
   logic [CW-1:0] i_ch     = '0;
   logic [IW-1:0] i_data   = '0;
   logic          o_valid;
   logic [CW-1:0] o_ch;
   logic [OW-1:0] o_data;

   comb_chain #(.IW(IW), .OW(OW), .N(N), .M(M), .CH(CH), .CW(CW)) dut (
      .lr_clock (lr_clock),
      .reset    (reset),
      .i_valid  (i_valid),
      .i_ch     (i_ch),
      .i_data   (i_data),
      .o_valid  (o_valid),
      .o_ch     (o_ch),
      .o_data   (o_data)
   );

   always #5 lr_clock = ~lr_clock;

   typedef struct {
      logic [CW-1:0] ch;
      logic [OW-1:0] data;
      int            stamp;
   } exp_t;

   exp_t          sb_q[$];
   longint        hist [CH][HL];
   int            cycle_cnt = 0;
   int            n_vec = 0;
   int            n_err = 0;
   logic [OW-1:0] last_data = '0;
   exp_t          mon_e;

   always @(posedge lr_clock) cycle_cnt++;

   function automatic longint binom(input int n, input int k);
      longint r = 1;
      for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
      return r;
   endfunction

   task automatic clear_model();
      for (int c = 0; c < CH; c++)
         for (int j = 0; j < HL; j++) hist[c][j] = 0;
      sb_q.delete();
   endtask

   task automatic check(input string name, input longint got, input longint want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // One transaction per call: drive at negedge, predict the response if accepted.
   task automatic apply(input logic v, input logic [CW-1:0] ch, input logic [IW-1:0] d);
      longint sum;
      exp_t   e;
      @(negedge lr_clock);
      i_valid = v;
      i_ch    = ch;
      i_data  = d;
      if (v && (int'(ch) < CH)) begin
         for (int j = HL-1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
         hist[ch][0] = longint'($signed(d));
         sum = 0;
         for (int j = 0; j <= N; j++) begin
            if (j % 2 == 1) sum -= binom(N, j) * hist[ch][j*M];
            else            sum += binom(N, j) * hist[ch][j*M];
         end
         e.ch    = ch;
         e.data  = OW'(sum);
         e.stamp = cycle_cnt;
         sb_q.push_back(e);
         $display("in  cyc=%0d ch=%0d data=%0d exp=%0d", cycle_cnt, ch, $signed(d), $signed(e.data));
      end else if (v) begin
         $display("in  cyc=%0d ch=%0d dropped", cycle_cnt, ch);
      end
   endtask

   always @(negedge lr_clock) begin
      if (reset) begin
         last_data = '0;
      end else if (o_valid) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid: got o_valid=1 ch=%0d data=%0d, expected o_valid=0", o_ch, $signed(o_data));
         end else begin
            mon_e = sb_q.pop_front();
            if (o_ch !== mon_e.ch || o_data !== mon_e.data || cycle_cnt != mon_e.stamp + N) begin
               n_err++;
               $display("FAIL sample: got ch=%0d data=%0d cyc=%0d, expected ch=%0d data=%0d cyc=%0d",
                        o_ch, $signed(o_data), cycle_cnt, mon_e.ch, $signed(mon_e.data), mon_e.stamp + N);
            end
         end
         last_data = o_data;
      end else begin
         n_vec++;
         if (o_data !== last_data) begin
            n_err++;
            $display("FAIL hold: got o_data=%0d, expected %0d", $signed(o_data), $signed(last_data));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          v;
      logic [CW-1:0] ch;
      logic [IW-1:0] d;
      int            r;
      int            waited;

      clear_model();
      repeat (3) @(posedge lr_clock);
      #1;
      check("reset_o_valid", longint'(o_valid), 0);
      check("reset_o_ch", longint'(o_ch), 0);
      check("reset_o_data", longint'(o_data), 0);
      reset = 1'b0;

      // Impulse with bubbles and a bad channel on channel 0.
      apply(1, 0, 19'd5);
      apply(0, 0, 19'd77);
      apply(1, 0, 19'd0);
      apply(1, 3, 19'd123);
      apply(1, 0, 19'd0);
      apply(0, 1, 19'd9);
      apply(1, 0, 19'd0);
      // Step on channel 2, interleaved with wrap extremes on channel 1.
      for (int i = 0; i < 6; i++) begin
         apply(1, 2, 19'd1);
         apply(1, 1, (i % 2 == 0) ? 19'h40000 : 19'h3FFFF);
      end

      for (int i = 0; i < 1500; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         ch = CW'($urandom_range(0, 3));
         r  = $urandom_range(0, 9);
         if (r == 0)      d = 19'h40000;
         else if (r == 1) d = 19'h3FFFF;
         else             d = IW'($urandom);
         apply(v, ch, d);
      end

      // Asynchronous reset with samples in flight.
      apply(1, 0, 19'd11);
      apply(1, 1, 19'd22);
      apply(1, 2, 19'd33);
      @(posedge lr_clock);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_o_valid", longint'(o_valid), 0);
      check("async_reset_o_data", longint'(o_data), 0);
      clear_model();
      repeat (2) @(posedge lr_clock);
      #3;
      reset = 1'b0;
      apply(1, 0, 19'd7);
      for (int i = 0; i < 40; i++) apply(1, CW'($urandom_range(0, 2)), IW'($urandom));
      apply(0, 0, 19'd0);

      waited = 0;
      while (sb_q.size() != 0 && waited < 20) begin
         @(negedge lr_clock);
         waited++;
      end
      #1;
      check("drain_pending", longint'(sb_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/comb_chain.md
Name: comb_chain

Overview:
Parametrised CIC comb section for the microphone decimation path. It cascades N comb stages, each computing y[n] = x[n] - x[n-M] with differential delay M. It keeps independent delay state for CH time-multiplexed channels (e.g. L/R sharing one datapath) and runs on a single clock with a sample-valid strobe. It sits after the integrator/decimator and before output scaling/serialisation.

Parameters:
IW, 19, input sample width (two's complement)
OW, 19, output/internal width; OW >= IW
N, 3, number of cascaded comb stages (1..8)
M, 1, differential delay in samples per channel (1..4)
CH, 2, number of interleaved channels (1..4)
CW, 1, channel index width; CW >= clog2(CH), minimum 1

Ports:
lr_clock  input  1  sole clock, all logic on posedge
reset  input  1  asynchronous, active-high; clears all state
i_valid  input  1  sample strobe; i_data/i_ch accepted on posedge when high
i_ch  input  CW  channel index of the current sample
i_data  input  IW  input sample, signed
o_valid  output  1  output sample strobe
o_ch  output  CW  channel index of o_data
o_data  output  OW  comb-chain output, signed

Behaviour:
- Reset (async assert, sync release by design): o_valid=0, o_ch=0, o_data=0, all stage registers and every delay-line entry = 0.
- Input conditioning: i_data is sign-extended to OW bits.
- Sample acceptance: a sample is accepted when i_valid=1 and i_ch < CH. If i_ch >= CH, the sample is dropped: no state change, no o_valid.
- Stage k (k=1..N): registered output. A valid input x for channel c gives y = x - D[k][c][M-1], computed modulo 2^OW with wrap and no saturation.
- Delay-line update: in the same cycle, D[k][c] shifts (D[k][c][0] <= x). Only channel c's line in stage k shifts. Other channels and invalid cycles leave it untouched.
- Pipeline: valid, channel and data propagate one stage per cycle.
- Latency: o_valid is asserted exactly N cycles after an accepted i_valid, with o_ch equal to that sample's i_ch.
- Throughput: full rate. i_valid may be high every cycle; channels may arrive in any order.
- Gaps: cycles with i_valid=0 are bubbles. They propagate as o_valid=0. o_data holds its last value when o_valid=0.
- Post-reset start-up: the first M samples of each channel see zero history, so stage output = stage input.
- Reset mid-operation: in-flight samples are discarded (o_valid=0 from reset assertion onward). Delay history is zeroed, so the first post-reset samples behave as from power-up.
- Storage: N*CH*M*OW delay bits plus N pipeline registers. No memories; implemented as register arrays.

Test Plan:
- Impulse, N=1 M=1 CH=1, IW=OW=19: i_data 5,0,0,0 on consecutive valids -> o_data 5,-5,0,0, each 1 cycle after its input.
- Step, N=3 M=1 CH=1: i_data 1 held on every valid -> o_data 1,-2,1,0,0..., first o_valid 3 cycles after first i_valid.
- Wrap-around, N=1 M=1, IW=OW=19: i_data -262144 then 262143 -> o_data -262144, then -1 (0x7FFFF, modular wrap).
- Interleave, N=1 M=2 CH=2: alternating L=100 (ch0) and R=-50 (ch1), constant -> outputs L:100,100,0... and R:-50,-50,0..., with o_ch matching and no cross-channel leakage.
- Bubbles and bad channel, N=2 M=1 CH=2: insert i_valid=0 cycles and one sample with i_ch=3 -> dropped/invalid cycles give o_valid=0 and leave results identical to the gap-free run.
- Async reset mid-stream, N=3: assert reset between posedges while samples are in flight -> o_valid drops immediately. After release, input 7 (first sample) -> o_data 7 three cycles later.
